// File: rtl/rps_frame_capture_pkg.sv
// Shared constants and types for the rock-paper-scissors capture/classifier path.
package rps_frame_capture_pkg;

    // Image geometry shared with the classifier.
    localparam int LENGTH = 32;
    localparam int WIDTH  = 32;

    // Classifier constants, kept alongside the geometry they depend on.
    localparam int LEFT   = 16;
    localparam int SHIFT  = 4;

    // Default grayscale pixel width.
    localparam int PIX_W  = 8;

    // Capture FSM states.
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } cap_state_t;

endpackage

// File: rtl/rps_pixel_binarize.sv
// Combinational threshold (and optional invert) of one grayscale pixel.
module rps_pixel_binarize #(
    parameter int PIX_W     = 8,
    parameter int THRESHOLD = 128,
    parameter bit INVERT    = 1'b0
) (
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_bit
);

    // One extra bit so a threshold of 2^PIX_W (never set) stays representable.
    localparam logic [PIX_W:0] TH = (PIX_W+1)'(THRESHOLD);

    assign pix_bit = ({1'b0, pix_data} >= TH) ^ INVERT;

endmodule

// File: rtl/rps_frame_capture.sv
// Captures a raster grayscale stream into a binary LENGTH x WIDTH frame and
// holds it (init_out high) until the downstream classifier acknowledges it.
module rps_frame_capture
    import rps_frame_capture_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int THRESHOLD = 128,
    parameter bit INVERT    = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [PIX_W-1:0]               pix_data,
    input  logic                           pix_sof,
    output logic [LENGTH-1:0][WIDTH-1:0]   image,
    output logic                           init_out,
    input  logic                           frame_ack,
    output logic                           frame_err,
    output logic [15:0]                    frame_cnt
);

    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(LENGTH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

    cap_state_t    state;
    logic [RW-1:0] row, wr_row;
    logic [CW-1:0] col, wr_col;
    logic          pix_bit;
    logic          xfer;
    logic          wr_en;

    rps_pixel_binarize #(
        .PIX_W     (PIX_W),
        .THRESHOLD (THRESHOLD),
        .INVERT    (INVERT)
    ) u_bin (
        .pix_data (pix_data),
        .pix_bit  (pix_bit)
    );

    // Ready depends on state only, never on pix_valid.
    assign pix_ready = (state != HOLD);
    assign xfer      = pix_valid && pix_ready;

    // In SYNC only an sof pixel is kept; in FILL every transferred pixel is.
    assign wr_en     = xfer && (pix_sof || (state == FILL));

    // An sof pixel always lands at (0,0), restarting any partial frame.
    assign wr_row    = pix_sof ? '0 : row;
    assign wr_col    = pix_sof ? '0 : col;

    // Capture FSM: write pixels, advance raster position, hold and release frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            row       <= '0;
            col       <= '0;
            image     <= '0;
            init_out  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                SYNC, FILL: begin
                    if (wr_en) begin
                        image[wr_row][wr_col] <= pix_bit;
                        frame_err             <= (state == FILL) && pix_sof;
                        if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
                            state     <= HOLD;
                            init_out  <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            row       <= '0;
                            col       <= '0;
                        end else begin
                            state <= FILL;
                            if (wr_col == COL_LAST) begin
                                col <= '0;
                                row <= wr_row + 1'b1;
                            end else begin
                                col <= wr_col + 1'b1;
                                row <= wr_row;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        state    <= SYNC;
                        init_out <= 1'b0;
                        row      <= '0;
                        col      <= '0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
